wash_ctrl_param: RTL and testbench

//  Parametrised washing-machine sequencer, successor to the fixed five-mode controller.

---
 rtl/wash_ctrl_param.sv | 158 +++++++++++++++
 tb/tb_wash_ctrl_param.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/wash_ctrl_param.sv
// wash_ctrl_param
//   Parametrised washing-machine sequencer:
//   Standby -> Fill -> [Soak] -> Wash -> {Fill -> Rinse} x RINSE_CNT -> Spin -> Standby.
//   Each phase lasts exactly its *_T cycles. Running time is frozen while pause
//   or door_open is high. The door stays locked whenever a cycle is running.
//
//   Build option: define WASH_SOAK_EN to insert a Soak phase (mode 5, SOAK_T
//   cycles) between the first Fill and Wash. Without it no Soak logic exists.
//
// Ports
//   clk         in   1      rising-edge clock
//   rst         in   1      synchronous reset, active-low
//   start       in   1      begin a cycle (Standby only, door must be closed)
//   pause       in   1      level; holds the running phase
//   door_open   in   1      door sensor, 1 = open; also holds the running phase
//   mode        out  3      0 Standby, 1 Fill, 2 Rinse, 3 Wash, 4 Spin, 5 Soak
//   phase_left  out  CNT_W  cycles left in current phase minus 1; 0 in Standby
//   rinse_idx   out  3      rinse pair in progress (1..RINSE_CNT), else 0
//   busy        out  1      mode != Standby
//   paused      out  1      running but held by pause/door_open
//   door_lock   out  1      same as busy
//   done        out  1      one-cycle pulse after Spin -> Standby
module wash_ctrl_param #(
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned FILL_T    = 4,
    parameter int unsigned WASH_T    = 8,
    parameter int unsigned RINSE_T   = 6,
    parameter int unsigned SPIN_T    = 5,
    parameter int unsigned RINSE_CNT = 2,
    parameter int unsigned SOAK_T    = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             pause,
    input  logic             door_open,
    output logic [2:0]       mode,
    output logic [CNT_W-1:0] phase_left,
    output logic [2:0]       rinse_idx,
    output logic             busy,
    output logic             paused,
    output logic             door_lock,
    output logic             done
);

    localparam int unsigned MAX_T = (1 << CNT_W) - 1;

    // Parameter sanity: a bad duration stops elaboration instead of silently wrapping.
    if (FILL_T < 1 || FILL_T > MAX_T || WASH_T < 1 || WASH_T > MAX_T ||
        RINSE_T < 1 || RINSE_T > MAX_T || SPIN_T < 1 || SPIN_T > MAX_T ||
        SOAK_T < 1 || SOAK_T > MAX_T || RINSE_CNT > 7) begin : g_bad_param
        $error("wash_ctrl_param: parameter out of range");
    end

    localparam logic [CNT_W-1:0] FILL_L  = CNT_W'(FILL_T - 1);
    localparam logic [CNT_W-1:0] WASH_L  = CNT_W'(WASH_T - 1);
    localparam logic [CNT_W-1:0] RINSE_L = CNT_W'(RINSE_T - 1);
    localparam logic [CNT_W-1:0] SPIN_L  = CNT_W'(SPIN_T - 1);
`ifdef WASH_SOAK_EN
    localparam logic [CNT_W-1:0] SOAK_L  = CNT_W'(SOAK_T - 1);
`endif
    localparam logic [2:0]       RC      = 3'(RINSE_CNT);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_RINSE = 3'd2,
        ST_WASH  = 3'd3,
        ST_SPIN  = 3'd4,
        ST_SOAK  = 3'd5
    } state_t;

    state_t state;

    assign mode      = state;
    assign busy      = (state != ST_IDLE);
    assign door_lock = busy;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            phase_left <= '0;
            rinse_idx  <= '0;
            paused     <= 1'b0;
            done       <= 1'b0;
        end else begin
            done   <= 1'b0;
            paused <= 1'b0;
            if (state == ST_IDLE) begin
                if (start && !door_open) begin
                    state      <= ST_FILL;
                    phase_left <= FILL_L;
                end
            end else if (pause || door_open) begin
                paused <= 1'b1;
            end else if (phase_left != '0) begin
                phase_left <= phase_left - CNT_W'(1);
            end else begin
                case (state)
                    // rinse_idx == 0 marks the initial fill; otherwise it feeds a rinse.
                    ST_FILL: begin
                        if (rinse_idx == '0) begin
`ifdef WASH_SOAK_EN
                            state      <= ST_SOAK;
                            phase_left <= SOAK_L;
`else
                            state      <= ST_WASH;
                            phase_left <= WASH_L;
`endif
                        end else begin
                            state      <= ST_RINSE;
                            phase_left <= RINSE_L;
                        end
                    end
`ifdef WASH_SOAK_EN
                    ST_SOAK: begin
                        state      <= ST_WASH;
                        phase_left <= WASH_L;
                    end
`endif
                    ST_WASH: begin
                        if (RC == '0) begin
                            state      <= ST_SPIN;
                            phase_left <= SPIN_L;
                        end else begin
                            state      <= ST_FILL;
                            phase_left <= FILL_L;
                            rinse_idx  <= rinse_idx + 3'd1;
                        end
                    end
                    ST_RINSE: begin
                        if (rinse_idx < RC) begin
                            state      <= ST_FILL;
                            phase_left <= FILL_L;
                            rinse_idx  <= rinse_idx + 3'd1;
                        end else begin
                            state      <= ST_SPIN;
                            phase_left <= SPIN_L;
                            rinse_idx  <= '0;
                        end
                    end
                    ST_SPIN: begin
                        state      <= ST_IDLE;
                        phase_left <= '0;
                        rinse_idx  <= '0;
                        done       <= 1'b1;
                    end
                    default: begin
                        state      <= ST_IDLE;
                        phase_left <= '0;
                        rinse_idx  <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_wash_ctrl_param.sv
// Testbench for wash_ctrl_param: directed checks of the nominal sequence and
// door interlock, then randomized start/pause/door/reset stimulus against a
// phase-list reference model.
module tb_wash_ctrl_param;

    localparam int CNT_W     = 8;
    localparam int FILL_T    = 4;
    localparam int WASH_T    = 8;
    localparam int RINSE_T   = 6;
    localparam int SPIN_T    = 5;
    localparam int RINSE_CNT = 2;
    localparam int SOAK_T    = 10;

    logic             clk = 1'b0;
    logic             rst, start, pause, door_open;
    logic [2:0]       mode;
    logic [CNT_W-1:0] phase_left;
    logic [2:0]       rinse_idx;
    logic             busy, paused, door_lock, done;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    wash_ctrl_param #(
        .CNT_W    (CNT_W),
        .FILL_T   (FILL_T),
        .WASH_T   (WASH_T),
        .RINSE_T  (RINSE_T),
        .SPIN_T   (SPIN_T),
        .RINSE_CNT(RINSE_CNT),
        .SOAK_T   (SOAK_T)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .pause     (pause),
        .door_open (door_open),
        .mode      (mode),
        .phase_left(phase_left),
        .rinse_idx (rinse_idx),
        .busy      (busy),
        .paused    (paused),
        .door_lock (door_lock),
        .done      (done)
    );

    // Reference model: the cycle is a flat list of (mode, length, rinse pair)
    // entries; the model walks it by index and elapsed-cycle count.
    int pm[$];
    int pl[$];
    int pr[$];
    bit m_busy, m_paused, m_done;
    int pi, el;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic build_list();
        pm.push_back(1); pl.push_back(FILL_T); pr.push_back(0);
`ifdef WASH_SOAK_EN
        pm.push_back(5); pl.push_back(SOAK_T); pr.push_back(0);
`endif
        pm.push_back(3); pl.push_back(WASH_T); pr.push_back(0);
        for (int k = 1; k <= RINSE_CNT; k++) begin
            pm.push_back(1); pl.push_back(FILL_T);  pr.push_back(k);
            pm.push_back(2); pl.push_back(RINSE_T); pr.push_back(k);
        end
        pm.push_back(4); pl.push_back(SPIN_T); pr.push_back(0);
    endtask

    task automatic model_edge(input bit r, input bit s, input bit p, input bit d);
        if (!r) begin
            m_busy = 0; m_paused = 0; m_done = 0; pi = 0; el = 0;
        end else begin
            m_done = 0; m_paused = 0;
            if (!m_busy) begin
                if (s && !d) begin m_busy = 1; pi = 0; el = 0; end
            end else if (p || d) begin
                m_paused = 1;
            end else if (el < pl[pi] - 1) begin
                el++;
            end else if (pi == pm.size() - 1) begin
                m_busy = 0; m_done = 1; pi = 0; el = 0;
            end else begin
                pi++; el = 0;
            end
        end
    endtask

    task automatic check_all();
        chk("mode",       32'(mode),       32'(m_busy ? pm[pi] : 0));
        chk("phase_left", 32'(phase_left), 32'(m_busy ? pl[pi] - 1 - el : 0));
        chk("rinse_idx",  32'(rinse_idx),  32'(m_busy ? pr[pi] : 0));
        chk("busy",       32'(busy),       32'(m_busy));
        chk("door_lock",  32'(door_lock),  32'(m_busy));
        chk("paused",     32'(paused),     32'(m_paused));
        chk("done",       32'(done),       32'(m_done));
    endtask

    task automatic step(input bit r, input bit s, input bit p, input bit d);
        rst = r; start = s; pause = p; door_open = d;
        @(posedge clk);
        model_edge(r, s, p, d);
        #1;
        check_all();
    endtask

    initial begin
        int lat;
        int total;
        build_list();
        total = 0;
        foreach (pl[i]) total += pl[i];

        // Reset state
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        chk("reset_mode", 32'(mode), 32'd0);

        // Start with door open is ignored
        step(1, 1, 0, 1);
        chk("door_start_mode", 32'(mode), 32'd0);

        // Nominal cycle with done latency
        step(1, 1, 0, 0);
        chk("start_pl", 32'(phase_left), 32'(FILL_T - 1));
        lat = 0;
        for (int i = 1; i <= total + 3; i++) begin
            step(1, 0, 0, 0);
            if (done && lat == 0) lat = i;
        end
        chk("done_latency", 32'(lat), 32'(total));

        // Pause during Wash holds phase_left
        step(1, 1, 0, 0);
        for (int i = 0; i < FILL_T + 4; i++) step(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 1, 0);
            chk("pause_hold", 32'(phase_left), 32'(WASH_T - 5));
        end
        step(1, 0, 0, 0);
        // Reset mid-operation, then restart
        step(0, 0, 0, 0);
        step(1, 1, 0, 0);
        chk("restart_pl", 32'(phase_left), 32'(FILL_T - 1));

        // Randomized stimulus
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 199) != 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 15) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
